mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
Sequencer placed directly upstream of the 16:1 gate-level multiplexer. It drives the mux 4-bit select, steps through channels 0..NUM_CH-1 on request, and waits a programmable settle time on each channel. It then samples the mux single-bit output into a parallel word and reports completion with a done pulse and a held valid flag. Downstream logic reads the whole scanned word without touching the mux directly.

Parameters:
NUM_CH, 16, number of channels scanned per pass; legal range 1..16.
SETTLE_CYCLES, 1, idle cycles after each select change before sampling; legal range 0..15.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  scan request; sampled only in IDLE.
mux_out  input  1  output of the 16:1 mux for the current sel.
sel  output  4  select driven to the mux input_sel.
busy  output  1  high while a scan is in progress (SETTLE or SAMPLE).
done  output  1  one-cycle pulse when a scan completes.
sample_valid  output  1  high from scan completion until the next accepted start or reset.
sample_data  output  16  scanned bits; bit i holds the sample of channel i.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset: state=IDLE, sel=0, busy=0, done=0, sample_valid=0, sample_data=0, settle counter=0. Reset overrides every other input, including mid-scan. No partial result survives a reset.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - sel=0, busy=0.
  - start=1 at edge E0: clear sample_data and sample_valid, set sel=0, load settle counter with SETTLE_CYCLES.
  - Next state is SETTLE, or SAMPLE if SETTLE_CYCLES=0.
- SETTLE:
  - busy=1; counter decrements each cycle.
  - Move to SAMPLE on the edge where the counter reaches 0, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE:
  - Lasts one cycle, busy=1.
  - At the closing edge, sample_data[sel] <= mux_out.
  - If sel==NUM_CH-1, go to DONE.
  - Otherwise sel <= sel+1, reload the counter, and go to SETTLE (or stay in SAMPLE if SETTLE_CYCLES=0).
- DONE:
  - Lasts one cycle: done=1, sample_valid=1, busy=0, sel holds NUM_CH-1.
  - Next state is IDLE; sel returns to 0 on entering IDLE.
- Timing: each channel takes SETTLE_CYCLES+1 cycles. The last capture occurs at edge E0+NUM_CH*(SETTLE_CYCLES+1), and done is high in the cycle that follows.
- start while busy or in DONE: ignored, not queued. Holding start high re-triggers only once the block is back in IDLE.
- sel never exceeds NUM_CH-1; no wrap-around within a pass.
- Bits NUM_CH..15 of sample_data are always 0.
- sample_data and sample_valid hold their values in IDLE until the next accepted start.
- All outputs are registered; sel changes only on clock edges.

Test Plan:
- Defaults; bench models the mux so that mux_out = bit sel of 16'hA5C3; pulse start:
  - sel steps 0..15, each value held 2 cycles.
  - done pulses exactly 32 cycles after the start edge.
  - sample_data=16'hA5C3, sample_valid=1.
- Defaults; start held high for 40 cycles → the second start is ignored during busy and DONE. A new scan begins only from IDLE, and sample_valid drops on that accept.
- Defaults; reset asserted while sel=7 → the next cycle shows sel=0, busy=0, done=0, sample_valid=0, sample_data=0. A subsequent start completes normally.
- NUM_CH=15, pattern 16'hFFFF → sel maxes at 14, done at 30 cycles, sample_data=16'h7FFF.
- SETTLE_CYCLES=0, pattern 16'h0001 → done at 16 cycles, sample_data=16'h0001, no SETTLE state visited.
- After a completed scan, hold start=0 for 10 cycles → sample_data and sample_valid are stable, sel=0, busy=0.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 16:1 mux select, waits a settle time per channel and captures every channel into a parallel word
module mux_scan_sequencer #(
   parameter int NUM_CH        = 16,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        mux_out,
   output logic [3:0]  sel,
   output logic        busy,
   output logic        done,
   output logic        sample_valid,
   output logic [15:0] sample_data
);
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
   localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);
   localparam logic [3:0] LP_LAST   = 4'(NUM_CH - 1);
   localparam state_t     LP_LOADED = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
   state_t      r_state, w_state_nx;
   logic [3:0]  r_cnt, w_cnt_nx, r_sel, w_sel_nx;
   logic [15:0] r_data, w_data_nx;
   logic        r_valid, w_valid_nx, r_busy, r_done;
   assign sel          = r_sel;
   assign busy         = r_busy;
   assign done         = r_done;
   assign sample_valid = r_valid;
   assign sample_data  = r_data;
   // state and output registers; busy/done are precomputed from the next state so they stay registered
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sel   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_sel   <= w_sel_nx;
         r_data  <= w_data_nx;
         r_valid <= w_valid_nx;
         r_busy  <= (w_state_nx == SETTLE) || (w_state_nx == SAMPLE);
         r_done  <= w_state_nx == DONE;
      end
   end
   // next-state logic: load on start, count down the settle time, capture one channel per SAMPLE
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_sel_nx   = r_sel;
      w_data_nx  = r_data;
      w_valid_nx = r_valid;
      case (r_state)
         IDLE: if (start) begin
            w_data_nx  = '0;
            w_valid_nx = 1'b0;
            w_sel_nx   = '0;
            w_cnt_nx   = LP_SETTLE;
            w_state_nx = LP_LOADED;
         end
         SETTLE: begin
            w_cnt_nx   = r_cnt - 4'd1;
            w_state_nx = (r_cnt <= 4'd1) ? SAMPLE : SETTLE;
         end
         SAMPLE: begin
            w_data_nx[r_sel] = mux_out;
            if (r_sel == LP_LAST) begin
               w_state_nx = DONE;
               w_valid_nx = 1'b1;
            end else begin
               w_sel_nx   = r_sel + 4'd1;
               w_cnt_nx   = LP_SETTLE;
               w_state_nx = LP_LOADED;
            end
         end
         DONE: begin
            w_state_nx = IDLE;
            w_sel_nx   = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed checks of three sequencer configurations against a behavioural mux
module tb_mux_scan_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start [3];
   logic        mux_out [3];
   logic [3:0]  sel [3];
   logic        busy [3];
   logic        done [3];
   logic        sample_valid [3];
   logic [15:0] sample_data [3];
   logic [15:0] pattern [3];
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          k;
      logic [15:0] pat;
      logic [15:0] exp_data;
      int          cyc;
      logic [3:0]  max_sel;
      int          hold;
   } vec_t;
   vec_t tbl [6];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_mux
      assign mux_out[g] = pattern[g][sel[g]];
   end

   mux_scan_sequencer u_def (.clk(clk), .reset(reset), .start(start[0]), .mux_out(mux_out[0]),
      .sel(sel[0]), .busy(busy[0]), .done(done[0]), .sample_valid(sample_valid[0]), .sample_data(sample_data[0]));
   mux_scan_sequencer #(.NUM_CH(15)) u_n15 (.clk(clk), .reset(reset), .start(start[1]), .mux_out(mux_out[1]),
      .sel(sel[1]), .busy(busy[1]), .done(done[1]), .sample_valid(sample_valid[1]), .sample_data(sample_data[1]));
   mux_scan_sequencer #(.SETTLE_CYCLES(0)) u_s0 (.clk(clk), .reset(reset), .start(start[2]), .mux_out(mux_out[2]),
      .sel(sel[2]), .busy(busy[2]), .done(done[2]), .sample_valid(sample_valid[2]), .sample_data(sample_data[2]));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_scan(input int k, input logic [15:0] pat, input logic [15:0] exp_data,
                           input int cyc, input logic [3:0] mx, input int hold);
      int n;
      int hist [16];
      logic [3:0] m;
      logic bz, hok;
      for (int i = 0; i < 16; i++) hist[i] = 0;
      pattern[k] = pat;
      start[k] = 1'b1;
      tick;
      start[k] = 1'b0;
      n = 0;
      m = '0;
      bz = 1'b1;
      while (!done[k] && n < 100) begin
         hist[sel[k]]++;
         if (sel[k] > m) m = sel[k];
         bz &= busy[k];
         tick;
         n++;
      end
      hok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i <= int'(m) && hist[i] != hold) hok = 1'b0;
         if (i > int'(m) && hist[i] != 0) hok = 1'b0;
      end
      chk("done_latency", n, cyc);
      chk("done_high", done[k], 1);
      chk("valid_at_done", sample_valid[k], 1);
      chk("data_at_done", sample_data[k], exp_data);
      chk("busy_at_done", busy[k], 0);
      chk("sel_at_done", sel[k], mx);
      chk("max_sel", m, mx);
      chk("busy_during_scan", bz, 1);
      chk("sel_hold_pattern", hok, 1);
      tick;
      chk("done_one_cycle", done[k], 0);
      chk("sel_back_to_0", sel[k], 0);
      chk("valid_held", sample_valid[k], 1);
      chk("data_held", sample_data[k], exp_data);
   endtask

   initial begin
      int n, dcnt;
      logic stable;
      tbl[0] = '{0, 16'hA5C3, 16'hA5C3, 32, 4'd15, 2};
      tbl[1] = '{1, 16'hFFFF, 16'h7FFF, 30, 4'd14, 2};
      tbl[2] = '{2, 16'h0001, 16'h0001, 16, 4'd15, 1};
      tbl[3] = '{0, 16'h0000, 16'h0000, 32, 4'd15, 2};
      tbl[4] = '{1, 16'h8001, 16'h0001, 30, 4'd14, 2};
      tbl[5] = '{2, 16'h5AF0, 16'h5AF0, 16, 4'd15, 1};
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0;
         pattern[k] = '0;
      end
      reset = 1'b1;
      repeat (3) tick;
      reset = 1'b0;
      chk("rst_sel", sel[0], 0);
      chk("rst_busy", busy[0], 0);
      chk("rst_done", done[0], 0);
      chk("rst_valid", sample_valid[0], 0);
      chk("rst_data", sample_data[0], 0);

      for (int i = 0; i < 6; i++)
         run_scan(tbl[i].k, tbl[i].pat, tbl[i].exp_data, tbl[i].cyc, tbl[i].max_sel, tbl[i].hold);

      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (sample_data[0] !== 16'h0000 || sample_valid[0] !== 1'b1 || sel[0] !== 4'd0 || busy[0] !== 1'b0)
            stable = 1'b0;
      end
      chk("idle_hold_stable", stable, 1);
      chk("idle_hold_data", sample_data[2], 16'h5AF0);

      pattern[0] = 16'h3C96;
      start[0] = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (done[0]) dcnt++;
         if (i == 20) chk("held_busy_mid", busy[0], 1);
         if (i == 32) chk("held_done_first", done[0], 1);
         if (i == 33) begin
            chk("held_idle_busy", busy[0], 0);
            chk("held_idle_valid", sample_valid[0], 1);
         end
         if (i == 34) begin
            chk("held_reaccept_busy", busy[0], 1);
            chk("held_reaccept_valid", sample_valid[0], 0);
            chk("held_reaccept_data", sample_data[0], 0);
         end
      end
      start[0] = 1'b0;
      chk("held_done_count", dcnt, 1);
      n = 0;
      while (!done[0] && n < 100) begin
         tick;
         n++;
      end
      chk("held_second_latency", n, 27);
      chk("held_second_data", sample_data[0], 16'h3C96);
      tick;

      pattern[0] = 16'hA5C3;
      start[0] = 1'b1;
      tick;
      start[0] = 1'b0;
      n = 0;
      while (sel[0] != 4'd7 && n < 50) begin
         tick;
         n++;
      end
      chk("sel7_reached", n, 14);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("midrst_sel", sel[0], 0);
      chk("midrst_busy", busy[0], 0);
      chk("midrst_done", done[0], 0);
      chk("midrst_valid", sample_valid[0], 0);
      chk("midrst_data", sample_data[0], 0);
      run_scan(0, 16'hA5C3, 16'hA5C3, 32, 4'd15, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
